apmu_ibex_pmp_csr: RTL and testbench

- CSR-side register file that produces the PMP configuration consumed by the PMP access checker.
- Services pmpcfg/pmpaddr CSR reads and writes through a req/gnt/rvalid handshake.
- Applies WARL legalisation and lock rules, then drives per-region cfg and 34-bit address vectors.
- Emits a one-cycle update pulse so fetch/LSU can flush on any PMP state change.

---
 rtl/apmu_ibex_pmp_csr.sv | 174 +++++++++++++++++
 tb/tb_apmu_ibex_pmp_csr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apmu_ibex_pmp_csr.sv
// apmu_ibex_pmp_csr
//   CSR-side PMP register file. Services pmpcfg0..3 (0x3A0..0x3A3) and
//   pmpaddr0..15 (0x3B0..0x3BF) through a req/gnt/rvalid handshake, applies
//   WARL legalisation and lock rules, and drives the per-region cfg/address
//   vectors consumed by the PMP checker.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   csr_req_i/we_i/addr_i/wdata_i   request, held stable until csr_gnt_o
//   csr_gnt_o             one-cycle accept pulse (GRANT state)
//   csr_rvalid_o          one-cycle response pulse, with csr_rdata_o/csr_err_o
//   csr_pmp_cfg_o         per-region {lock, mode, exec, write, read}
//   csr_pmp_addr_o        per-region {pmpaddr[31:0], 2'b00}
//   pmp_upd_o             one-cycle pulse after any stored-state change

package apmu_ibex_pmp_pkg;
  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_mode_e;

  typedef struct packed {
    logic      lock;
    pmp_mode_e mode;
    logic      exec;
    logic      write;
    logic      read;
  } pmp_cfg_t;
endpackage

module apmu_ibex_pmp_csr
  import apmu_ibex_pmp_pkg::*;
#(
  parameter int PMPGranularity = 0,
  parameter int PMPNumRegions  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               csr_req_i,
  input  logic                               csr_we_i,
  input  logic [11:0]                        csr_addr_i,
  input  logic [31:0]                        csr_wdata_i,
  output logic                               csr_gnt_o,
  output logic                               csr_rvalid_o,
  output logic [31:0]                        csr_rdata_o,
  output logic                               csr_err_o,
  output pmp_cfg_t [PMPNumRegions-1:0]       csr_pmp_cfg_o,
  output logic [PMPNumRegions-1:0][33:0]     csr_pmp_addr_o,
  output logic                               pmp_upd_o
);

  // Low address bits forced on read: NAPOT sets [G-2:0], OFF/TOR clear [G-1:0].
  localparam logic [31:0] GMASK      = (32'd1 << PMPGranularity) - 32'd1;
  localparam logic [31:0] NAPOT_ONES = GMASK >> 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_e;

  state_e                          state_q, state_d;
  logic                            gnt_q, gnt_d;
  logic                            rvalid_q, rvalid_d;
  logic                            err_q, err_d;
  logic                            upd_q, upd_d;
  logic [31:0]                     rdata_q, rdata_d;
  pmp_cfg_t [PMPNumRegions-1:0]    cfg_q, cfg_d;
  logic [PMPNumRegions-1:0][31:0]  addr_q, addr_d;

  logic [PMPNumRegions-1:0]        tor_lock;
  logic                            sel_cfg, sel_addr, commit;
  logic [31:0]                     rd_val;

  assign sel_cfg  = (csr_addr_i[11:2] == 10'h0E8);  // 0x3A0..0x3A3
  assign sel_addr = (csr_addr_i[11:4] == 8'h3B);    // 0x3B0..0x3BF
  assign commit   = (state_q == S_GRANT) && csr_we_i;

  function automatic pmp_cfg_t legalise(input logic [7:0] b);
    pmp_cfg_t c;
    c.lock  = b[7];
    c.mode  = pmp_mode_e'(b[4:3]);
    c.exec  = b[2];
    c.write = b[1];
    c.read  = b[0];
    if (!c.read && c.write) c.write = 1'b0;
    if (PMPGranularity >= 1 && c.mode == PMP_NA4) c.mode = PMP_OFF;
    return c;
  endfunction

  // Register file update and read mux
  always_comb begin
    tor_lock = '0;
    // A locked TOR region also freezes the address below it (its bottom bound).
    for (int i = 0; i < PMPNumRegions - 1; i++)
      tor_lock[i] = cfg_q[i+1].lock && (cfg_q[i+1].mode == PMP_TOR);

    cfg_d  = cfg_q;
    addr_d = addr_q;
    if (commit) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (sel_cfg && csr_addr_i[1:0] == 2'(i / 4) && !cfg_q[i].lock)
          cfg_d[i] = legalise(csr_wdata_i[8*(i%4) +: 8]);
        if (sel_addr && csr_addr_i[3:0] == 4'(i) && !cfg_q[i].lock && !tor_lock[i])
          addr_d[i] = csr_wdata_i;
      end
    end

    rd_val = '0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      if (sel_cfg && csr_addr_i[1:0] == 2'(i / 4))
        rd_val[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
      if (sel_addr && csr_addr_i[3:0] == 4'(i))
        rd_val = cfg_q[i].mode[1] ? (addr_q[i] | NAPOT_ONES) : (addr_q[i] & ~GMASK);
    end
  end

  // Handshake FSM; all outputs registered
  always_comb begin
    state_d  = state_q;
    gnt_d    = 1'b0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    upd_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      S_IDLE: if (csr_req_i) begin
        state_d = S_GRANT;
        gnt_d   = 1'b1;
      end
      S_GRANT: begin
        state_d  = S_RESP;
        rvalid_d = 1'b1;
        err_d    = !(sel_cfg || sel_addr);
        rdata_d  = csr_we_i ? '0 : rd_val;
        upd_d    = (cfg_d != cfg_q) || (addr_d != addr_q);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      rdata_q  <= '0;
      cfg_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      rdata_q  <= rdata_d;
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
    end
  end

  assign csr_gnt_o     = gnt_q;
  assign csr_rvalid_o  = rvalid_q;
  assign csr_err_o     = err_q;
  assign csr_rdata_o   = rdata_q;
  assign pmp_upd_o     = upd_q;
  assign csr_pmp_cfg_o = cfg_q;

  for (genvar g = 0; g < PMPNumRegions; g++) begin : g_addr
    assign csr_pmp_addr_o[g] = {addr_q[g], 2'b00};
  end

endmodule

// File: tb/tb_apmu_ibex_pmp_csr.sv
// Bench for apmu_ibex_pmp_csr: one instance with 4-byte granule (a), one
// with PMPGranularity=2 (b). Each access pushes its expected response into a
// per-instance queue; a monitor pops and compares on every rvalid.
module tb_apmu_ibex_pmp_csr;
  import apmu_ibex_pmp_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        upd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [11:0]       addr_a = '0, addr_b = '0;
  logic [31:0]       wd_a = '0, wd_b = '0;
  logic              gnt_a, rvalid_a, err_a, upd_a, gnt_b, rvalid_b, err_b, upd_b;
  logic [31:0]       rdata_a, rdata_b;
  pmp_cfg_t [3:0]    cfg_a, cfg_b;
  logic [3:0][33:0]  paddr_a, paddr_b;

  apmu_ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) u_a (
    .clk_i(clk), .rst_i(rst), .csr_req_i(req_a), .csr_we_i(we_a),
    .csr_addr_i(addr_a), .csr_wdata_i(wd_a), .csr_gnt_o(gnt_a),
    .csr_rvalid_o(rvalid_a), .csr_rdata_o(rdata_a), .csr_err_o(err_a),
    .csr_pmp_cfg_o(cfg_a), .csr_pmp_addr_o(paddr_a), .pmp_upd_o(upd_a));

  apmu_ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(4)) u_b (
    .clk_i(clk), .rst_i(rst), .csr_req_i(req_b), .csr_we_i(we_b),
    .csr_addr_i(addr_b), .csr_wdata_i(wd_b), .csr_gnt_o(gnt_b),
    .csr_rvalid_o(rvalid_b), .csr_rdata_o(rdata_b), .csr_err_o(err_b),
    .csr_pmp_cfg_o(cfg_b), .csr_pmp_addr_o(paddr_b), .pmp_upd_o(upd_b));

  int   tests = 0, fails = 0;
  int   upd_cnt_a = 0, upd_cnt_b = 0, exp_upd_a = 0, exp_upd_b = 0;
  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) if (!rst) begin
    if (upd_a) upd_cnt_a++;
    if (rvalid_a) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        e_a = q_a.pop_front();
        check("a_rdata", rdata_a, e_a.rdata);
        check("a_err",   err_a,   e_a.err);
        check("a_upd",   upd_a,   e_a.upd);
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (upd_b) upd_cnt_b++;
    if (rvalid_b) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        e_b = q_b.pop_front();
        check("b_rdata", rdata_b, e_b.rdata);
        check("b_err",   err_b,   e_b.err);
        check("b_upd",   upd_b,   e_b.upd);
      end
    end
  end

  // One access: issue, check gnt/rvalid latency, return to IDLE.
  task automatic access(input bit b, input bit we, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] er,
                        input bit ee, input bit eu);
    exp_t e;
    int   n;
    e.rdata = er; e.err = ee; e.upd = eu;
    if (b) begin q_b.push_back(e); if (eu) exp_upd_b++; end
    else   begin q_a.push_back(e); if (eu) exp_upd_a++; end
    @(negedge clk);
    if (b) begin we_b = we; addr_b = addr; wd_b = wd; req_b = 1; end
    else   begin we_a = we; addr_a = addr; wd_a = wd; req_a = 1; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(b ? gnt_b : gnt_a) && n < 8);
    check(b ? "b_gnt_latency" : "a_gnt_latency", n, 1);
    if (b) req_b = 0; else req_a = 0;
    @(negedge clk);
    check(b ? "b_rvalid_latency" : "a_rvalid_latency", b ? rvalid_b : rvalid_a, 1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_gnt",    gnt_a,    0);
    check("rst_rvalid", rvalid_a, 0);
    check("rst_err",    err_a,    0);
    check("rst_upd",    upd_a,    0);
    check("rst_rdata",  rdata_a,  0);
    check("rst_cfg",    cfg_a,    0);
    check("rst_addr0",  paddr_a[0], 0);
    rst = 0;

    // ---- instance a: granule 4 bytes ----
    access(0, 0, 12'h3A0, 0,             32'h0,        0, 0);
    access(0, 0, 12'h3B0, 0,             32'h0,        0, 0);
    access(0, 1, 12'h3A0, 32'h0000_1F03, 32'h0,        0, 1);
    check("a_cfg0_after_1f03", cfg_a[0], 6'h03);
    check("a_cfg1_after_1f03", cfg_a[1], 6'h1F);
    access(0, 1, 12'h3A0, 32'h0000_1F02, 32'h0,        0, 1);  // W-only -> 0
    check("a_cfg0_w_only", cfg_a[0], 6'h00);
    access(0, 0, 12'h3A0, 0,             32'h0000_1F00, 0, 0);
    access(0, 1, 12'h3B0, 32'h0000_0ABC, 32'h0,        0, 1);
    check("a_addr0_out", paddr_a[0], 34'h2AF0);
    access(0, 1, 12'h3A0, 32'h0000_8800, 32'h0,        0, 1);  // cfg1 = L,TOR
    check("a_cfg1_locked_tor", cfg_a[1], 6'h28);
    access(0, 1, 12'h3B0, 32'h0000_1234, 32'h0,        0, 0);  // TOR-top locked
    access(0, 0, 12'h3B0, 0,             32'h0000_0ABC, 0, 0);
    access(0, 1, 12'h3A0, 32'h0000_0000, 32'h0,        0, 0);  // byte1 locked
    access(0, 0, 12'h3A0, 0,             32'h0000_8800, 0, 0);
    access(0, 1, 12'h3A0, 32'h0000_0001, 32'h0,        0, 1);  // byte0 still updates
    access(0, 0, 12'h3A0, 0,             32'h0000_8801, 0, 0);
    access(0, 1, 12'h3B2, 32'h0000_0055, 32'h0,        0, 1);
    access(0, 0, 12'h3B2, 0,             32'h0000_0055, 0, 0);
    access(0, 1, 12'h3B1, 32'h0000_0077, 32'h0,        0, 0);  // cfg1.L
    access(0, 0, 12'h3B1, 0,             32'h0,        0, 0);
    access(0, 1, 12'h3A0, 32'h009D_8801, 32'h0,        0, 1);  // set L in same write
    access(0, 1, 12'h3A0, 32'h0000_8801, 32'h0,        0, 0);  // now locked
    access(0, 0, 12'h3A0, 0,             32'h009D_8801, 0, 0);
    access(0, 1, 12'h3B2, 32'h0000_0066, 32'h0,        0, 0);
    access(0, 0, 12'h3B2, 0,             32'h0000_0055, 0, 0);
    access(0, 0, 12'h3C0, 0,             32'h0,        1, 0);
    access(0, 1, 12'h3C0, 32'hFFFF_FFFF, 32'h0,        1, 0);
    access(0, 0, 12'h3A1, 0,             32'h0,        0, 0);  // unimplemented
    access(0, 1, 12'h3B5, 32'h0000_0001, 32'h0,        0, 0);

    // ---- instance b: PMPGranularity = 2 ----
    access(1, 1, 12'h3A0, 32'h0000_0010, 32'h0,        0, 0);  // NA4 -> OFF
    access(1, 0, 12'h3A0, 0,             32'h0,        0, 0);
    access(1, 1, 12'h3A0, 32'h0000_0018, 32'h0,        0, 1);  // NAPOT
    access(1, 0, 12'h3A0, 0,             32'h0000_0018, 0, 0);
    access(1, 1, 12'h3B0, 32'h0000_0100, 32'h0,        0, 1);
    access(1, 0, 12'h3B0, 0,             32'h0000_0101, 0, 0);
    access(1, 1, 12'h3A0, 32'h0000_0008, 32'h0,        0, 1);  // TOR
    access(1, 1, 12'h3B0, 32'h0000_0103, 32'h0,        0, 1);
    access(1, 0, 12'h3B0, 0,             32'h0000_0100, 0, 0);
    check("b_addr0_full_storage", paddr_b[0], 34'h40C);
    access(1, 1, 12'h3A0, 32'h0000_0006, 32'h0,        0, 1);  // XW -> X
    access(1, 0, 12'h3A0, 0,             32'h0000_0004, 0, 0);
    access(1, 1, 12'h3A0, 32'h0000_0013, 32'h0,        0, 1);  // NA4 RW -> OFF RW
    access(1, 0, 12'h3A0, 0,             32'h0000_0003, 0, 0);

    check("a_upd_pulse_count", upd_cnt_a, exp_upd_a);
    check("b_upd_pulse_count", upd_cnt_b, exp_upd_b);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    // ---- reset during GRANT drops the transaction ----
    @(negedge clk);
    we_a = 1; addr_a = 12'h3B3; wd_a = 32'h0000_FFFF; req_a = 1;
    @(negedge clk);
    check("rst_mid_in_grant", gnt_a, 1);
    rst = 1; req_a = 0;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt_a || rvalid_a) seen = 1;
    end
    check("rst_mid_no_response", seen, 0);
    check("rst_mid_cfg_a", cfg_a, 0);
    check("rst_mid_cfg_b", cfg_b, 0);
    check("rst_mid_addr0", paddr_a[0], 0);
    check("rst_mid_addr2", paddr_a[2], 0);
    check("rst_mid_addr3", paddr_a[3], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
